jk_down_counter: RTL and testbench

- Synchronous down counter, WIDTH bits wide, built from JK flip-flop cells. It is the counting-down counterpart of the team's synchronous JK up counter.
- Supports parallel load, count enable, optional auto-reload and a registered borrow pulse.
- Used as a programmable countdown/timer stage alongside the up counter in the lab datapath.

---
 rtl/jk_down_counter_pkg.sv | 23 ++
 rtl/jk_down_counter_jkff.sv | 37 +++
 rtl/jk_down_counter.sv | 99 +++++++++
 tb/tb_jk_down_counter.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/jk_down_counter_pkg.sv
// ---------------------------------------------------------------------------
// jk_down_counter_pkg
//   Shared JK control codes for the JK-flip-flop based counters.
//   A code is the {J, K} pair applied to one flip-flop cell:
//     JK_HOLD : keep the current value
//     JK_RST  : force the bit to 0
//     JK_SET  : force the bit to 1
//     JK_TGL  : invert the bit
//   jk_for_value() returns the code that makes a bit take a given value
//   on the next edge, which is how parallel load and reload are done.
// ---------------------------------------------------------------------------
package jk_down_counter_pkg;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    function automatic logic [1:0] jk_for_value(input logic v);
        return v ? JK_SET : JK_RST;
    endfunction

endpackage

// File: rtl/jk_down_counter_jkff.sv
// ---------------------------------------------------------------------------
// jk_down_counter_jkff
//   Single JK flip-flop cell with a synchronous active-low clear.
//   Ports:
//     clk_i    : rising-edge clock
//     clearb_i : synchronous clear, active low (q_o <= 0 on the edge)
//     j_i, k_i : JK inputs (00 hold, 01 reset, 10 set, 11 toggle)
//     q_o      : stored bit
// ---------------------------------------------------------------------------
module jk_down_counter_jkff
    import jk_down_counter_pkg::*;
(
    input  logic clk_i,
    input  logic clearb_i,
    input  logic j_i,
    input  logic k_i,
    output logic q_o
);

    logic q_q;

    always_ff @(posedge clk_i) begin
        if (!clearb_i) begin
            q_q <= 1'b0;
        end else begin
            case ({j_i, k_i})
                JK_RST:  q_q <= 1'b0;
                JK_SET:  q_q <= 1'b1;
                JK_TGL:  q_q <= ~q_q;
                default: q_q <= q_q;
            endcase
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/jk_down_counter.sv
// ---------------------------------------------------------------------------
// jk_down_counter
//   Synchronous WIDTH-bit down counter built from JK flip-flop cells, with
//   parallel load, count enable, optional auto-reload and a registered
//   one-cycle borrow pulse. Edge priority: clear > load > en > hold.
//   Ports:
//     clk         : rising-edge clock
//     clear       : synchronous active-high reset (q, reload register, borrow)
//     en          : decrement by one per enabled edge
//     load        : capture load_val into q and the reload register
//     load_val    : parallel load value
//     auto_reload : on underflow, 1 = reload from reload register, 0 = wrap
//     q           : current count
//     zero        : combinational q == 0
//     borrow      : high for one cycle after each underflow edge
// ---------------------------------------------------------------------------
module jk_down_counter
    import jk_down_counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] q,
    output logic             zero,
    output logic             borrow
);

    logic [WIDTH-1:0] q_w;
    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] reload_d;
    logic             borrow_q;
    logic             borrow_d;
    logic [1:0]       jk_d [WIDTH];
    logic             underflow;
    logic             lower_zero;

    // An underflow is an enabled count that consumes q == 0; a load on the
    // same edge takes priority and suppresses it.
    assign underflow = en && !load && (q_w == '0);

    always_comb begin
        lower_zero = 1'b1;
        reload_d   = reload_q;
        borrow_d   = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            jk_d[i] = JK_HOLD;
        end

        if (load) begin
            reload_d = load_val;
            for (int i = 0; i < WIDTH; i++) begin
                jk_d[i] = jk_for_value(load_val[i]);
            end
        end else if (underflow && auto_reload) begin
            borrow_d = 1'b1;
            for (int i = 0; i < WIDTH; i++) begin
                jk_d[i] = jk_for_value(reload_q[i]);
            end
        end else if (en) begin
            // Decrement: bit i toggles when every lower bit is 0. At q == 0
            // every bit toggles, which yields the all-ones wrap for free.
            borrow_d = underflow;
            for (int i = 0; i < WIDTH; i++) begin
                jk_d[i]    = lower_zero ? JK_TGL : JK_HOLD;
                lower_zero = lower_zero & ~q_w[i];
            end
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        jk_down_counter_jkff u_jkff (
            .clk_i    (clk),
            .clearb_i (~clear),
            .j_i      (jk_d[g][1]),
            .k_i      (jk_d[g][0]),
            .q_o      (q_w[g])
        );
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            reload_q <= '0;
            borrow_q <= 1'b0;
        end else begin
            reload_q <= reload_d;
            borrow_q <= borrow_d;
        end
    end

    assign q      = q_w;
    assign zero   = (q_w == '0);
    assign borrow = borrow_q;

endmodule

// File: tb/tb_jk_down_counter.sv
// ---------------------------------------------------------------------------
// tb_jk_down_counter
//   Self-checking bench for jk_down_counter (WIDTH = 4). Each driven cycle
//   pushes the expected {q, zero, borrow} from a behavioural model onto
//   exp_q; after the edge the DUT output is popped and compared.
// ---------------------------------------------------------------------------
module tb_jk_down_counter;

    localparam int W  = 4;
    localparam int VW = W + 2;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         clear = 1'b0;
    logic         en = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         auto_reload = 1'b0;
    logic [W-1:0] q;
    logic         zero;
    logic         borrow;

    always #5 clk = ~clk;

    jk_down_counter #(.WIDTH(W)) dut (
        .clk         (clk),
        .clear       (clear),
        .en          (en),
        .load        (load),
        .load_val    (load_val),
        .auto_reload (auto_reload),
        .q           (q),
        .zero        (zero),
        .borrow      (borrow)
    );

    // ---------------- scoreboard ----------------
    logic [VW-1:0] exp_q[$];
    int            n_vec = 0;
    int            n_err = 0;

    logic [W-1:0]  m_q = '0;
    logic [W-1:0]  m_r = '0;
    logic          m_b = 1'b0;

    task automatic check_vec(input string tag, input logic [VW-1:0] obs,
                             input logic [VW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got q=%0d zero=%0b borrow=%0b, want q=%0d zero=%0b borrow=%0b",
                     tag, obs[VW-1:2], obs[1], obs[0], exp[VW-1:2], exp[1], exp[0]);
        end
    endtask

    // Behavioural reference: plain arithmetic, independent of the JK form.
    task automatic model_step(input logic c, input logic l, input logic [W-1:0] lv,
                              input logic e, input logic ar);
        if (c) begin
            m_q = '0; m_r = '0; m_b = 1'b0;
        end else if (l) begin
            m_q = lv; m_r = lv; m_b = 1'b0;
        end else if (e) begin
            if (m_q != '0) begin
                m_q = m_q - 1'b1; m_b = 1'b0;
            end else begin
                m_q = ar ? m_r : '1; m_b = 1'b1;
            end
        end else begin
            m_b = 1'b0;
        end
        exp_q.push_back({m_q, (m_q == '0), m_b});
    endtask

    // ---------------- driver ----------------
    task automatic step(input string tag, input logic c, input logic l,
                        input logic [W-1:0] lv, input logic e, input logic ar);
        logic [VW-1:0] exp;
        @(negedge clk);
        clear = c; load = l; load_val = lv; en = e; auto_reload = ar;
        model_step(c, l, lv, e, ar);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL %s: scoreboard empty, got q=%0d", tag, q);
        end else begin
            exp = exp_q.pop_front();
            check_vec(tag, {q, zero, borrow}, exp);
        end
    endtask

    task automatic count(input string tag, input int n, input logic ar);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, '0, 1'b1, ar);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset and basic count: 0 -> 15 (borrow) -> 14 -> 13
        step("reset", 1'b1, 1'b0, '0, 1'b0, 1'b0);
        step("reset", 1'b1, 1'b1, 4'd7, 1'b1, 1'b1);
        check_vec("reset_const", {q, zero, borrow}, {4'd0, 1'b1, 1'b0});
        count("wrap", 3, 1'b0);

        // Load and countdown with wrap
        step("load5", 1'b0, 1'b1, 4'd5, 1'b0, 1'b0);
        count("down5", 6, 1'b0);
        check_vec("wrap_const", {q, zero, borrow}, {4'd15, 1'b0, 1'b1});

        // Auto-reload from 3
        step("load3", 1'b0, 1'b1, 4'd3, 1'b1, 1'b1);
        count("reload3", 8, 1'b1);

        // Priority: load beats an underflow on the same edge
        step("load0", 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        step("ld_vs_uf", 1'b0, 1'b1, 4'd9, 1'b1, 1'b1);
        check_vec("ld_vs_uf_const", {q, zero, borrow}, {4'd9, 1'b0, 1'b0});
        step("load0b", 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        step("clr_vs_all", 1'b1, 1'b1, 4'd9, 1'b1, 1'b1);

        // Hold, then mid-count clear, then reload-from-zero underflows
        step("load12", 1'b0, 1'b1, 4'd12, 1'b0, 1'b1);
        count("down12", 3, 1'b1);
        for (int i = 0; i < 3; i++) step("hold", 1'b0, 1'b0, 4'd4, 1'b0, 1'b1);
        step("midclr", 1'b1, 1'b0, '0, 1'b1, 1'b1);
        count("zero_reload", 3, 1'b1);

        // Reload-zero corner via load 0
        step("load0c", 1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
        count("rz_corner", 4, 1'b1);
        check_vec("rz_const", {q, zero, borrow}, {4'd0, 1'b1, 1'b1});

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step("random",
                 ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 9) == 0),
                 W'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 1) == 1));
        end

        if (exp_q.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
